alu: RTL and testbench
======================

Name: alu

Overview:
- 8-bit ALU for the single-cycle processor datapath. It is driven by the register-file read operands and a 4-bit opcode from the decoder.
- Computes arithmetic, logic, shift and compare results, plus a Zero flag used by branch logic.
- Result and flag are registered: one clock of latency.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 4, opcode width in bits.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InputA  input  WIDTH  operand A (rs).
- InputB  input  WIDTH  operand B (rd).
- OP  input  OPW  operation select; values come from the shared opcode enum.
- Out  output  WIDTH  registered result.
- Zero  output  1  registered flag; 1 when the registered Out equals 0.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset_n low: immediately Out=8'h00 and Zero=1, held while low. Normal operation resumes on the first rising Clk after release.
- Each rising Clk (Reset_n high): Out <= f(OP, InputA, InputB); Zero <= (f(...) == 0). Latency is exactly 1 cycle.
- No handshake. A new operation is accepted every cycle. Inputs are sampled only at the clock edge.
- Opcode encodings and functions (all unsigned; unused upper result bits = 0):
  - kADD=4'h0: A+B, modulo 2^8; carry discarded, 8'hFF+1 -> 8'h00.
  - kRXOR=4'h1: {7'b0, ^A}, reduction XOR (parity) of A only; B ignored.
  - kXOR=4'h2: A^B, bitwise.
  - kAND=4'h3: A&B, bitwise.
  - kLSH=4'h4: A>>1, logical, MSB filled with 0; B ignored.
  - SEQ=4'h5: 8'h01 if A==B, else 8'h00.
  - SLT=4'h6: 8'h01 if B<A (rd less than rs, unsigned), else 8'h00. A==B gives 0.
  - JEQ=4'h7: 8'h01 if A==B, else 8'h00; the branch unit uses !Zero as the take-branch signal.
  - kACK=4'h8: A, pass-through.
  - 4'h9..4'hF: reserved; Out=8'h00, Zero=1.
- Zero always reflects the value just registered into Out; it never lags Out.
- Reset asserted mid-operation: the in-flight result is discarded and outputs are forced to reset values asynchronously.
- No X propagation: every OP value yields a defined result.

Decomposition:
- Shared package "definitions":
  - op_t, a 4-bit enum: kADD, kRXOR, kXOR, kAND, kLSH, SEQ, SLT, JEQ, kACK with the encodings above.
  - Width constants.
- One natural sub-module, alu_comb: the purely combinational function f (case on OP) producing next_out and next_zero.
- The top alu instantiates alu_comb and holds the two output flops with async active-low reset.

Test Plan:
- Reset: Reset_n=0 mid-cycle -> Out=0x00, Zero=1 without waiting for Clk. Release, apply A=10, B=1, kADD -> after one edge Out=11, Zero=0. Also A=0xFF, B=1, kADD -> Out=0x00, Zero=1.
- kRXOR: A=10, B=10 -> Out=0, Zero=1. A=2 -> Out=1, Zero=0.
- kXOR: A=10, B=10 -> Out=0, Zero=1. Then kAND with same inputs -> Out=10.
- kLSH: A=2, B=0 -> Out=1. A=0x81 -> Out=0x40.
- SEQ: A=4, B=4 -> Out=1. SLT: A=10, B=5 -> Out=1; A=5, B=10 -> Out=0; A=B=7 -> Out=0.
- JEQ: A=B=3 -> Out=1, Zero=0. A=3, B=4 -> Out=0, Zero=1. kACK: A=0x5A -> Out=0x5A. OP=4'hC -> Out=0, Zero=1. Check every result appears exactly one edge after its inputs.

Source files
------------

// File: rtl/definitions.sv
// Shared ALU definitions: the width constants and the opcode encoding that
// the decoder and the ALU must agree on.
package definitions;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    kADD  = 4'h0,
    kRXOR = 4'h1,
    kXOR  = 4'h2,
    kAND  = 4'h3,
    kLSH  = 4'h4,
    SEQ   = 4'h5,
    SLT   = 4'h6,
    JEQ   = 4'h7,
    kACK  = 4'h8
  } op_t;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU function: selects the result for the current
// opcode and derives the zero flag from that same result.
module alu_comb
  import definitions::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW   = OP_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] next_out,
  output logic             next_zero
);

  logic a_eq_b;
  logic b_lt_a;

  assign a_eq_b = (a == b);
  assign b_lt_a = (b < a);

  always_comb begin
    next_out = '0;
    // Reserved opcodes fall through to the zero default.
    case (op_t'(op))
      kADD:    next_out = a + b;
      kRXOR:   next_out = {{(WIDTH-1){1'b0}}, ^a};
      kXOR:    next_out = a ^ b;
      kAND:    next_out = a & b;
      kLSH:    next_out = a >> 1;
      SEQ:     next_out = {{(WIDTH-1){1'b0}}, a_eq_b};
      SLT:     next_out = {{(WIDTH-1){1'b0}}, b_lt_a};
      JEQ:     next_out = {{(WIDTH-1){1'b0}}, a_eq_b};
      kACK:    next_out = a;
      default: next_out = '0;
    endcase
    next_zero = (next_out == '0);
  end

endmodule

// File: rtl/alu.sv
// 8-bit registered ALU: one cycle from operands/opcode to Out and Zero.
// Zero is registered alongside Out so the two can never disagree.
module alu
  import definitions::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW   = OP_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [OPW-1:0]   OP,
  output logic [WIDTH-1:0] Out,
  output logic             Zero
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             zero_d;
  logic             zero_q;

  alu_comb #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_comb (
    .a        (InputA),
    .b        (InputB),
    .op       (OP),
    .next_out (out_d),
    .next_zero(zero_d)
  );

  // Reset value is an all-zero result, so Zero resets high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign Out  = out_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal cases plus random traffic
// compared every cycle against a behavioural model.
module tb_alu;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic [7:0] Out;
  logic       Zero;

  int errors = 0;
  int checks = 0;

  logic [7:0] expOut;
  logic       expZero;
  bit         modelEn = 0;

  alu dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .InputA (InputA),
    .InputB (InputB),
    .OP     (OP),
    .Out    (Out),
    .Zero   (Zero)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  function automatic int modelAlu(input int a, input int b, input int op);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (a / (1 << i)) % 2;
    case (op)
      0:       return (a + b) % 256;
      1:       return ones % 2;
      2:       return a ^ b;
      3:       return a & b;
      4:       return a / 2;
      5:       return (a == b) ? 1 : 0;
      6:       return (b < a) ? 1 : 0;
      7:       return (a == b) ? 1 : 0;
      8:       return a;
      default: return 0;
    endcase
  endfunction

  // Reference result that the DUT should be holding right now.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      expOut  <= 8'h00;
      expZero <= 1'b1;
    end else begin
      expOut  <= 8'(modelAlu(int'(InputA), int'(InputB), int'(OP)));
      expZero <= (modelAlu(int'(InputA), int'(InputB), int'(OP)) == 0);
    end
  end

  always @(negedge Clk) begin
    if (modelEn) begin
      checks++;
      if (Out !== expOut || Zero !== expZero) begin
        errors++;
        $display("[TB] FAIL model A=%02h B=%02h OP=%0h: got Out=%02h Zero=%b, expected Out=%02h Zero=%b",
                 InputA, InputB, OP, Out, Zero, expOut, expZero);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge Clk);
    InputA = a;
    InputB = b;
    OP     = op;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eOut, input logic eZero);
    @(posedge Clk);
    #1;
    checks++;
    if (Out !== eOut || Zero !== eZero) begin
      errors++;
      $display("[TB] FAIL %s: got Out=%02h Zero=%b, expected Out=%02h Zero=%b",
               name, Out, Zero, eOut, eZero);
    end
  endtask

  task automatic checkNow(input string name, input logic [7:0] eOut, input logic eZero);
    checks++;
    if (Out !== eOut || Zero !== eZero) begin
      errors++;
      $display("[TB] FAIL %s: got Out=%02h Zero=%b, expected Out=%02h Zero=%b",
               name, Out, Zero, eOut, eZero);
    end
  endtask

  initial begin
    Reset_n = 1;
    InputA  = 8'h37;
    InputB  = 8'h11;
    OP      = 4'h0;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 0;
    #1;
    checkNow("reset_async", 8'h00, 1'b1);
    @(posedge Clk);
    #1;
    checkNow("reset_held", 8'h00, 1'b1);
    @(negedge Clk);
    Reset_n = 1;
    modelEn = 1;

    applyStimulus(8'd10, 8'd1, 4'h0);   checkOutput("add_10_1", 8'd11, 1'b0);
    applyStimulus(8'hFF, 8'd1, 4'h0);   checkOutput("add_wrap", 8'h00, 1'b1);
    applyStimulus(8'd10, 8'd10, 4'h1);  checkOutput("rxor_10", 8'h00, 1'b1);
    applyStimulus(8'd2, 8'd10, 4'h1);   checkOutput("rxor_2", 8'h01, 1'b0);
    applyStimulus(8'd10, 8'd10, 4'h2);  checkOutput("xor_same", 8'h00, 1'b1);
    applyStimulus(8'd10, 8'd10, 4'h3);  checkOutput("and_same", 8'd10, 1'b0);
    applyStimulus(8'd2, 8'd0, 4'h4);    checkOutput("lsh_2", 8'h01, 1'b0);
    applyStimulus(8'h81, 8'd0, 4'h4);   checkOutput("lsh_81", 8'h40, 1'b0);
    applyStimulus(8'd4, 8'd4, 4'h5);    checkOutput("seq_eq", 8'h01, 1'b0);
    applyStimulus(8'd10, 8'd5, 4'h6);   checkOutput("slt_b_lt_a", 8'h01, 1'b0);
    applyStimulus(8'd5, 8'd10, 4'h6);   checkOutput("slt_b_gt_a", 8'h00, 1'b1);
    applyStimulus(8'd7, 8'd7, 4'h6);    checkOutput("slt_equal", 8'h00, 1'b1);
    applyStimulus(8'd3, 8'd3, 4'h7);    checkOutput("jeq_eq", 8'h01, 1'b0);
    applyStimulus(8'd3, 8'd4, 4'h7);    checkOutput("jeq_ne", 8'h00, 1'b1);
    applyStimulus(8'h5A, 8'hC3, 4'h8);  checkOutput("ack_5a", 8'h5A, 1'b0);
    applyStimulus(8'h5A, 8'hC3, 4'hC);  checkOutput("reserved_c", 8'h00, 1'b1);

    // Result must not appear before the edge that samples the inputs.
    applyStimulus(8'h20, 8'h03, 4'h0);  checkOutput("latency_prev", 8'h23, 1'b0);
    applyStimulus(8'h01, 8'h01, 4'h2);
    #1;
    checkNow("latency_hold", 8'h23, 1'b0);
    checkOutput("latency_next", 8'h00, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      applyStimulus(a, b, 4'($urandom_range(0, 15)));
    end

    // Mid-cycle reset discards the pending result.
    applyStimulus(8'h44, 8'h22, 4'h0);
    @(posedge Clk);
    #3;
    Reset_n = 0;
    #1;
    checkNow("reset_midop", 8'h00, 1'b1);
    @(negedge Clk);
    Reset_n = 1;
    applyStimulus(8'h0F, 8'hF0, 4'h3);  checkOutput("after_reset", 8'h00, 1'b1);
    applyStimulus(8'h0F, 8'hF1, 4'h2);  checkOutput("after_reset_xor", 8'hFE, 1'b0);

    @(negedge Clk);
    modelEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
